// File: rtl/arduino_cmd_tx.sv
// Command transmitter to the whack-a-mole Arduino: 4-deep command FIFO feeding a
// framed 8-bit serial link (frame/clock/data) with acknowledge, timeout and retry.
module arduino_cmd_tx #(
  parameter int CLK_DIV     = 250,
  parameter int ACK_TIMEOUT = 50000,
  parameter int MAX_TRIES   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic       tx_frame,
  output logic       tx_clk,
  output logic       tx_data,
  input  logic       ack_in,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] sent_count
);

  localparam int CNT_MAX = (ACK_TIMEOUT > CLK_DIV) ? ACK_TIMEOUT : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, WAIT_ACK, GAP, GAP_RETRY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [7:0]      word_q, word_d;
  logic [7:0]      sent_q, sent_d;
  logic            err_q, err_d;

  logic [3:0][5:0] fifo_q, fifo_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;

  logic [1:0]      ack_sync_q, ack_sync_d;
  logic            ack_prev_q, ack_prev_d, ack_edge_q, ack_edge_d;

  logic            tx_frame_q, tx_frame_d, tx_clk_q, tx_clk_d, tx_data_q, tx_data_d;

  logic            fifo_full, fifo_empty, push, pop, div_done, to_done;
  logic [5:0]      head;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign push       = cmd_valid & ~fifo_full;
  assign pop        = (state_q == IDLE) & ~fifo_empty;
  assign head       = fifo_q[rd_ptr_q];
  assign div_done   = (cnt_q == CW'(CLK_DIV - 1));
  assign to_done    = (cnt_q == CW'(ACK_TIMEOUT - 1));

  assign cmd_ready   = ~fifo_full;
  assign busy        = (state_q != IDLE) | ~fifo_empty;
  assign timeout_err = err_q;
  assign sent_count  = sent_q;
  assign tx_frame    = tx_frame_q;
  assign tx_clk      = tx_clk_q;
  assign tx_data     = tx_data_q;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {cmd_op, cmd_arg};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Sync stages plus a registered rising-edge pulse; a held-high ack gives one edge.
  always_comb begin
    ack_sync_d = {ack_sync_q[0], ack_in};
    ack_prev_d = ack_sync_q[1];
    ack_edge_d = ack_sync_q[1] & ~ack_prev_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tries_d = tries_q;
    word_d  = word_q;
    sent_d  = sent_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          word_d  = {head, ^head, 1'b1};
          tries_d = TW'(1);
          bit_d   = 3'd7;
          cnt_d   = '0;
          state_d = BIT_LO;
        end
      end
      BIT_LO: begin
        if (div_done) begin
          cnt_d   = '0;
          state_d = BIT_HI;
        end else cnt_d = cnt_q + CW'(1);
      end
      BIT_HI: begin
        if (div_done) begin
          cnt_d = '0;
          if (bit_q == 3'd0) state_d = WAIT_ACK;
          else begin
            bit_d   = bit_q - 3'd1;
            state_d = BIT_LO;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      WAIT_ACK: begin
        // Ack is checked first so a simultaneous expiry still counts as success.
        if (ack_edge_q) begin
          sent_d  = sent_q + 8'd1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (to_done) begin
          cnt_d = '0;
          if (tries_q < TW'(MAX_TRIES)) begin
            tries_d = tries_q + TW'(1);
            state_d = GAP_RETRY;
          end else begin
            err_d   = 1'b1;
            state_d = GAP;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      GAP: begin
        if (div_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      GAP_RETRY: begin
        if (div_done) begin
          cnt_d   = '0;
          bit_d   = 3'd7;
          state_d = BIT_LO;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drivers are registered off the current state so the GPIOs never glitch.
  always_comb begin
    tx_frame_d = (state_q == BIT_LO) | (state_q == BIT_HI);
    tx_clk_d   = (state_q == BIT_HI);
    tx_data_d  = tx_frame_d & word_q[bit_q];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd7;
      tries_q    <= '0;
      word_q     <= '0;
      sent_q     <= '0;
      err_q      <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_sync_q <= '0;
      ack_prev_q <= 1'b0;
      ack_edge_q <= 1'b0;
      tx_frame_q <= 1'b0;
      tx_clk_q   <= 1'b0;
      tx_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tries_q    <= tries_d;
      word_q     <= word_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_sync_q <= ack_sync_d;
      ack_prev_q <= ack_prev_d;
      ack_edge_q <= ack_edge_d;
      tx_frame_q <= tx_frame_d;
      tx_clk_q   <= tx_clk_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Directed bench for arduino_cmd_tx: frames are decoded off the GPIO lines and
// compared with hand-computed words; all sampling is on the falling clock edge.
module tb_arduino_cmd_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_arg = '0;
  logic       tx_frame, tx_clk, tx_data;
  logic       ack_in = 1'b0;
  logic       busy, timeout_err;
  logic [7:0] sent_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_sent = 8'd0;

  arduino_cmd_tx #(.CLK_DIV(4), .ACK_TIMEOUT(64), .MAX_TRIES(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .tx_frame(tx_frame), .tx_clk(tx_clk),
    .tx_data(tx_data), .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err),
    .sent_count(sent_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] arg);
    @(negedge CLOCK_50);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  // Returns on the first sample with tx_frame low; w is bits sampled on tx_clk rises.
  task automatic capture(output logic [7:0] w, output int hi, output bit ok);
    int n;
    logic pc;
    w = '0; hi = 0; ok = 1'b0; n = 0;
    while (tx_frame !== 1'b1 && n < 400) begin @(negedge CLOCK_50); n++; end
    if (tx_frame !== 1'b1) return;
    pc = tx_clk;
    while (tx_frame === 1'b1 && hi < 400) begin
      if (tx_clk === 1'b1 && pc === 1'b0) w = {w[6:0], tx_data};
      pc = tx_clk;
      hi++;
      @(negedge CLOCK_50);
    end
    ok = 1'b1;
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) @(negedge CLOCK_50);
    ack_in = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    ack_in = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLOCK_50);
    n_cmp++; if (tx_frame !== 1'b0) begin n_err++; $display("FAIL rst_tx_frame got %b want 0", tx_frame); end
    n_cmp++; if (tx_clk !== 1'b0) begin n_err++; $display("FAIL rst_tx_clk got %b want 0", tx_clk); end
    n_cmp++; if (tx_data !== 1'b0) begin n_err++; $display("FAIL rst_tx_data got %b want 0", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    n_cmp++; if (sent_count !== 8'd0) begin n_err++; $display("FAIL rst_sent_count got %0d want 0", sent_count); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b0 || tx_frame !== 1'b0) begin n_err++; $display("FAIL post_rst_idle busy=%b frame=%b want 0 0", busy, tx_frame); end
  endtask

  task automatic test_single;
    logic [7:0] w; int hi; bit ok;
    @(negedge CLOCK_50);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 4'b0101;
    @(negedge CLOCK_50);  // after push edge k
    cmd_valid = 1'b0;
    n_cmp++; if (tx_frame !== 1'b0) begin n_err++; $display("FAIL single_k_frame got %b want 0", tx_frame); end
    @(negedge CLOCK_50);  // after k+1
    n_cmp++; if (tx_frame !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_k1 frame=%b busy=%b want 0 1", tx_frame, busy); end
    @(negedge CLOCK_50);  // after k+2
    n_cmp++; if (tx_frame !== 1'b1 || tx_data !== 1'b0 || tx_clk !== 1'b0) begin n_err++; $display("FAIL single_k2 frame=%b data=%b clk=%b want 1 0 0", tx_frame, tx_data, tx_clk); end
    capture(w, hi, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_frame_timeout got none want frame"); end
    n_cmp++; if (w !== 8'h15) begin n_err++; $display("FAIL single_word got %h want 15", w); end
    n_cmp++; if (hi !== 64) begin n_err++; $display("FAIL single_frame_len got %0d want 64", hi); end
    repeat (9) @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b1 || tx_clk !== 1'b0 || tx_data !== 1'b0) begin n_err++; $display("FAIL single_wait_ack busy=%b clk=%b data=%b want 1 0 0", busy, tx_clk, tx_data); end
    do_ack(0);
    exp_sent++;
    repeat (20) @(negedge CLOCK_50);
    n_cmp++; if (sent_count !== exp_sent) begin n_err++; $display("FAIL single_sent got %0d want %0d", sent_count, exp_sent); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_parity;
    logic [7:0] w; int hi; bit ok;
    send_cmd(2'b11, 4'b1111);
    capture(w, hi, ok);
    n_cmp++; if (!ok || w !== 8'hFD) begin n_err++; $display("FAIL parity_fd got %h ok=%0d want fd", w, ok); end
    do_ack(3); exp_sent++;
    send_cmd(2'b10, 4'b0001);
    capture(w, hi, ok);
    n_cmp++; if (!ok || w !== 8'h85) begin n_err++; $display("FAIL parity_85 got %h ok=%0d want 85", w, ok); end
    do_ack(3); exp_sent++;
    repeat (20) @(negedge CLOCK_50);
    n_cmp++; if (sent_count !== exp_sent) begin n_err++; $display("FAIL parity_sent got %0d want %0d", sent_count, exp_sent); end
  endtask

  task automatic test_ack_at_timeout;
    logic [7:0] w; int hi; bit ok; bit saw;
    send_cmd(2'b00, 4'b0001);
    capture(w, hi, ok);
    n_cmp++; if (!ok || w !== 8'h07) begin n_err++; $display("FAIL edge_word got %h want 07", w); end
    do_ack(59);  // lands on the last WAIT_ACK cycle
    exp_sent++;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin @(negedge CLOCK_50); if (tx_frame === 1'b1) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL edge_no_retry got retry want none"); end
    n_cmp++; if (sent_count !== exp_sent) begin n_err++; $display("FAIL edge_sent got %0d want %0d", sent_count, exp_sent); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL edge_timeout_err got %b want 0", timeout_err); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops [6];
    logic [3:0] args [6];
    logic [7:0] words [5];
    logic [7:0] w; int hi; bit ok;
    ops = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
    args = '{4'h0, 4'h3, 4'h9, 4'h7, 4'h2, 4'hE};
    words = '{8'h43, 8'h0D, 8'hA7, 8'h1F, 8'hCB};
    for (int j = 0; j < 6; j++) begin
      @(negedge CLOCK_50);
      cmd_valid = 1'b1; cmd_op = ops[j]; cmd_arg = args[j];
      n_cmp++; if (cmd_ready !== (j < 5)) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", j, cmd_ready, (j < 5)); end
    end
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      capture(w, hi, ok);
      n_cmp++; if (!ok || w !== words[j]) begin n_err++; $display("FAIL b2b_word[%0d] got %h want %h", j, w, words[j]); end
      do_ack(5);
      exp_sent++;
    end
    repeat (25) @(negedge CLOCK_50);
    n_cmp++; if (busy !== 1'b0 || tx_frame !== 1'b0) begin n_err++; $display("FAIL b2b_drained busy=%b frame=%b want 0 0", busy, tx_frame); end
    n_cmp++; if (sent_count !== exp_sent) begin n_err++; $display("FAIL b2b_sent got %0d want %0d", sent_count, exp_sent); end
  endtask

  task automatic test_retry;
    logic [7:0] w; int hi; bit ok; int gap;
    send_cmd(2'b00, 4'b1001);
    for (int t = 0; t < 3; t++) begin
      capture(w, hi, ok);
      n_cmp++; if (!ok || w !== 8'h25 || hi !== 64) begin n_err++; $display("FAIL retry_frame[%0d] got %h len %0d want 25 len 64", t, w, hi); end
      if (t < 2) begin
        gap = 0;
        while (tx_frame !== 1'b1 && gap < 200) begin gap++; @(negedge CLOCK_50); end
        n_cmp++; if (gap !== 68) begin n_err++; $display("FAIL retry_gap[%0d] got %0d want 68", t, gap); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL retry_err_early[%0d] got %b want 0", t, timeout_err); end
      end
    end
    repeat (75) @(negedge CLOCK_50);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL retry_timeout_err got %b want 1", timeout_err); end
    n_cmp++; if (sent_count !== exp_sent || busy !== 1'b0) begin n_err++; $display("FAIL retry_drop sent=%0d busy=%b want %0d 0", sent_count, busy, exp_sent); end
    send_cmd(2'b10, 4'b0100);
    capture(w, hi, ok);
    n_cmp++; if (!ok || w !== 8'h91) begin n_err++; $display("FAIL retry_follow_word got %h want 91", w); end
    do_ack(4); exp_sent++;
    repeat (20) @(negedge CLOCK_50);
    n_cmp++; if (sent_count !== exp_sent || timeout_err !== 1'b1) begin n_err++; $display("FAIL retry_follow sent=%0d err=%b want %0d 1", sent_count, timeout_err, exp_sent); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w; int hi; bit ok; int n; bit saw;
    @(negedge CLOCK_50);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 4'b0010;
    @(negedge CLOCK_50); cmd_op = 2'b11; cmd_arg = 4'hF;
    @(negedge CLOCK_50); cmd_op = 2'b01; cmd_arg = 4'h0;
    @(negedge CLOCK_50); cmd_valid = 1'b0;
    n = 0;
    while (tx_frame !== 1'b1 && n < 50) begin @(negedge CLOCK_50); n++; end
    repeat (37) @(negedge CLOCK_50);  // inside the high phase of bit 3
    n_cmp++; if (tx_frame !== 1'b1 || tx_clk !== 1'b1 || tx_data !== 1'b1) begin n_err++; $display("FAIL mid_pre frame=%b clk=%b data=%b want 1 1 1", tx_frame, tx_clk, tx_data); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({tx_frame, tx_clk, tx_data} !== 3'b000) begin n_err++; $display("FAIL mid_rst_lines got %b want 000", {tx_frame, tx_clk, tx_data}); end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_fifo busy=%b ready=%b want 0 1", busy, cmd_ready); end
    n_cmp++; if (sent_count !== 8'd0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_status sent=%0d err=%b want 0 0", sent_count, timeout_err); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    exp_sent = 8'd0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin @(negedge CLOCK_50); if (tx_frame === 1'b1 || busy === 1'b1) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL mid_flushed got activity want none"); end
    send_cmd(2'b01, 4'b1100);
    capture(w, hi, ok);
    n_cmp++; if (!ok || w !== 8'h73 || hi !== 64) begin n_err++; $display("FAIL mid_clean got %h len %0d want 73 len 64", w, hi); end
    do_ack(2); exp_sent++;
    repeat (20) @(negedge CLOCK_50);
    n_cmp++; if (sent_count !== exp_sent || busy !== 1'b0) begin n_err++; $display("FAIL mid_after sent=%0d busy=%b want %0d 0", sent_count, busy, exp_sent); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_parity;
    test_ack_at_timeout;
    test_back_to_back;
    test_retry;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
